// File: rtl/gfx_interp_pkg.sv
// gfx_interp shared types: FSM state encoding,
// default widths and the fixed-point 1.0 constant.
package gfx_interp_pkg;

  localparam int POINT_W = 16;
  localparam int FRACT_W = 16;

  localparam logic [FRACT_W:0] ONE = {1'b1, {FRACT_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/gfx_interp_divider.sv
// gfx_interp serial restoring divider: one fractional
// quotient bit per step, forced 0 / 1.0 results at load.
module gfx_interp_divider
  import gfx_interp_pkg::*;
#(
  parameter int point_width = POINT_W,
  parameter int fract_width = FRACT_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic                            step,
  input  logic signed [2*point_width-1:0] dividend,
  input  logic signed [2*point_width-1:0] divisor,
  output logic        [fract_width:0]     quotient
);

  localparam int DW = 2 * point_width;
  localparam int RW = DW + 1;
  localparam int QW = fract_width + 1;
  localparam logic [QW-1:0] one = {1'b1, {fract_width{1'b0}}};

  logic [RW-1:0] rem;
  logic [RW-1:0] rem_sh;
  logic [RW-1:0] rem_next;
  logic [DW-1:0] den;
  logic [QW-1:0] quo;
  logic          run;
  logic          qbit;

  // one restoring step; a forced result just passes through
  always_comb begin
    rem_sh   = rem << 1;
    qbit     = rem_sh >= {1'b0, den};
    rem_next = qbit ? rem_sh - {1'b0, den} : rem_sh;
    quotient = run ? ((quo << 1) | QW'(qbit)) : quo;
  end

  // classify at load, then iterate only for a true fraction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      den <= '0;
      quo <= '0;
      run <= 1'b0;
    end else if (load) begin
      den <= divisor;
      rem <= {1'b0, dividend};
      if (divisor <= 0 || dividend < 0) begin
        quo <= '0;
        run <= 1'b0;
      end else if (dividend >= divisor) begin
        quo <= one;
        run <= 1'b0;
      end else begin
        quo <= '0;
        run <= 1'b1;
      end
    end else if (step && run) begin
      rem <= rem_next;
      quo <= quotient;
    end
  end

endmodule

// File: rtl/gfx_interp.sv
// gfx_interp: barycentric weight normalization stage.
// Optional factor2 output enabled by GFX_INTERP_FACTOR2_EN.
module gfx_interp
  import gfx_interp_pkg::*;
#(
  parameter int point_width = POINT_W,
  parameter int fract_width = FRACT_W
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            write_i,
  output logic                            ack_o,
  input  logic        [point_width-1:0]   x_i,
  input  logic        [point_width-1:0]   y_i,
  input  logic signed [2*point_width-1:0] edge0_i,
  input  logic signed [2*point_width-1:0] edge1_i,
  input  logic signed [2*point_width-1:0] area_i,
  output logic                            write_o,
  input  logic                            ack_i,
  output logic        [point_width-1:0]   x_o,
  output logic        [point_width-1:0]   y_o,
  output logic        [fract_width:0]     factor0_o,
  output logic        [fract_width:0]     factor1_o,
  output logic        [fract_width:0]     factor2_o
);

  localparam int CW = $clog2(fract_width + 1);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [point_width-1:0] x_q;
  logic [point_width-1:0] y_q;
  logic [fract_width:0]   q0;
  logic [fract_width:0]   q1;
  logic                   load;
  logic                   step;
  logic                   last;

  assign load = (state == IDLE) && write_i;
  assign step = (state == DIV);
  assign last = step && (cnt == CW'(1));

  gfx_interp_divider #(
    .point_width(point_width),
    .fract_width(fract_width)
  ) u_div0 (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .load    (load),
    .step    (step),
    .dividend(edge0_i),
    .divisor (area_i),
    .quotient(q0)
  );

  gfx_interp_divider #(
    .point_width(point_width),
    .fract_width(fract_width)
  ) u_div1 (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .load    (load),
    .step    (step),
    .dividend(edge1_i),
    .divisor (area_i),
    .quotient(q1)
  );

  // control FSM, step counter and output handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      write_o   <= 1'b0;
      ack_o     <= 1'b0;
      x_o       <= '0;
      y_o       <= '0;
      factor0_o <= '0;
      factor1_o <= '0;
    end else begin
      ack_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (write_i) begin
            x_q   <= x_i;
            y_q   <= y_i;
            cnt   <= CW'(fract_width);
            state <= DIV;
          end
        end
        DIV: begin
          cnt <= cnt - CW'(1);
          if (last) begin
            write_o   <= 1'b1;
            x_o       <= x_q;
            y_o       <= y_q;
            factor0_o <= q0;
            factor1_o <= q1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (ack_i) begin
            write_o <= 1'b0;
            ack_o   <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GFX_INTERP_FACTOR2_EN
  localparam logic [fract_width+1:0] one_x = {2'b01, {fract_width{1'b0}}};

  logic [fract_width+1:0] fsum;

  assign fsum = {1'b0, q0} + {1'b0, q1};

  // third weight is the remainder of 1.0, clamped at 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      factor2_o <= '0;
    end else if (last) begin
      if (fsum > one_x) begin
        factor2_o <= '0;
      end else begin
        factor2_o <= (fract_width+1)'(one_x - fsum);
      end
    end
  end
`else
  assign factor2_o = '0;
`endif

endmodule

// File: tb/tb_gfx_interp.sv
// gfx_interp bench: random and directed pixels, a
// quotient reference model and a queue-based monitor.
module tb_gfx_interp;

  localparam int P = 16;
  localparam int F = 16;
  localparam longint ONEV = 64'd1 << F;

  logic                clk = 1'b0;
  logic                rst_ni = 1'b0;
  logic                write_i = 1'b0;
  logic                ack_i = 1'b0;
  logic [P-1:0]        x_i = '0;
  logic [P-1:0]        y_i = '0;
  logic signed [2*P-1:0] edge0_i = '0;
  logic signed [2*P-1:0] edge1_i = '0;
  logic signed [2*P-1:0] area_i = '0;
  logic                ack_o;
  logic                write_o;
  logic [P-1:0]        x_o;
  logic [P-1:0]        y_o;
  logic [F:0]          factor0_o;
  logic [F:0]          factor1_o;
  logic [F:0]          factor2_o;

  gfx_interp dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .write_i  (write_i),
    .ack_o    (ack_o),
    .x_i      (x_i),
    .y_i      (y_i),
    .edge0_i  (edge0_i),
    .edge1_i  (edge1_i),
    .area_i   (area_i),
    .write_o  (write_o),
    .ack_i    (ack_i),
    .x_o      (x_o),
    .y_o      (y_o),
    .factor0_o(factor0_o),
    .factor1_o(factor1_o),
    .factor2_o(factor2_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [P-1:0] x;
    logic [P-1:0] y;
    logic [F:0]   f0;
    logic [F:0]   f1;
    logic [F:0]   f2;
    longint       t;
  } exp_t;

  exp_t   sb[$];
  exp_t   cur;
  int     compared = 0;
  int     mismatched = 0;
  longint cyc = 0;

  function automatic logic [F:0] ref_div(longint e, longint a);
    if (a <= 0 || e < 0) return '0;
    if (e >= a) return (F+1)'(ONEV);
    return (F+1)'((e * ONEV) / a);
  endfunction

  function automatic logic [F:0] ref_f2(logic [F:0] f0, logic [F:0] f1);
`ifdef GFX_INTERP_FACTOR2_EN
    longint s;
    s = longint'(f0) + longint'(f1);
    if (s > ONEV) return '0;
    return (F+1)'(ONEV - s);
`else
    return '0;
`endif
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: ack pulse, latency, values and stability in OUT
  initial begin
    logic wo_prev;
    logic hs;
    forever begin
      @(posedge clk);
      wo_prev = write_o;
      hs = write_o && ack_i && rst_ni;
      #1;
      cyc++;
      if (!rst_ni) continue;
      check("ack_o", 128'(ack_o), 128'(hs));
      if (write_o && !wo_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_write_o", 128'(1), 128'(0));
        end else begin
          cur = sb.pop_front();
          check("latency", 128'(cyc - cur.t), 128'(F + 1));
          check("x_o", 128'(x_o), 128'(cur.x));
          check("y_o", 128'(y_o), 128'(cur.y));
          check("factor0", 128'(factor0_o), 128'(cur.f0));
          check("factor1", 128'(factor1_o), 128'(cur.f1));
          check("factor2", 128'(factor2_o), 128'(cur.f2));
        end
      end else if (write_o) begin
        check("hold", {x_o, y_o, factor0_o, factor1_o, factor2_o},
              {cur.x, cur.y, cur.f0, cur.f1, cur.f2});
      end
    end
  end

  task automatic issue(input logic [P-1:0] x, input logic [P-1:0] y,
                       input longint e0, input longint e1, input longint a);
    exp_t e;
    @(negedge clk);
    write_i = 1'b1;
    x_i = x;
    y_i = y;
    edge0_i = (2*P)'(e0);
    edge1_i = (2*P)'(e1);
    area_i = (2*P)'(a);
    e.x = x;
    e.y = y;
    e.f0 = ref_div(e0, a);
    e.f1 = ref_div(e1, a);
    e.f2 = ref_f2(e.f0, e.f1);
    e.t = cyc;
    sb.push_back(e);
    @(negedge clk);
    write_i = 1'b0;
    x_i = P'($urandom);
    y_i = P'($urandom);
    edge0_i = $urandom;
    edge1_i = $urandom;
    area_i = $urandom;
  endtask

  task automatic run_px(input logic [P-1:0] x, input logic [P-1:0] y,
                        input longint e0, input longint e1, input longint a,
                        input int ack_dly, input bit spur);
    int n;
    issue(x, y, e0, e1, a);
    if (spur) begin
      repeat (4) @(negedge clk);
      write_i = 1'b1;
      @(negedge clk);
      write_i = 1'b0;
    end
    n = 0;
    while (!write_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!write_o) begin
      check("write_o_timeout", 128'(0), 128'(1));
      sb.delete();
      return;
    end
    repeat (ack_dly) @(negedge clk);
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
  endtask

  initial begin
    longint a;
    longint e0;
    longint e1;
    repeat (3) @(negedge clk);
    check("rst_write_o", 128'(write_o), 128'(0));
    check("rst_ack_o", 128'(ack_o), 128'(0));
    check("rst_xy", 128'({x_o, y_o}), 128'(0));
    check("rst_f01", 128'({factor0_o, factor1_o}), 128'(0));
    check("rst_f2", 128'(factor2_o), 128'(0));
    rst_ni = 1'b1;

    run_px(16'd10, 16'd20, 50, 25, 100, 0, 1'b0);
    run_px(16'd1, 16'd2, 100, 0, 100, 0, 1'b0);
    run_px(16'd3, 16'd4, 150, 50, 100, 1, 1'b0);
    run_px(16'd5, 16'd6, 50, 25, 0, 2, 1'b0);
    run_px(16'd7, 16'd8, 50, 25, -5, 0, 1'b0);
    run_px(16'd9, 16'd11, 60, 60, 100, 5, 1'b1);
    run_px(16'hbeef, 16'h1234, 33, 66, 99, 0, 1'b0);

    issue(16'h55aa, 16'h0f0f, 70, 10, 100);
    repeat (7) @(negedge clk);
    rst_ni = 1'b0;
    sb.delete();
    @(posedge clk);
    #2;
    check("mid_rst_write_o", 128'(write_o), 128'(0));
    check("mid_rst_ack_o", 128'(ack_o), 128'(0));
    check("mid_rst_xy", 128'({x_o, y_o}), 128'(0));
    check("mid_rst_f", 128'({factor0_o, factor1_o, factor2_o}), 128'(0));
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_idle", 128'(write_o), 128'(0));
    run_px(16'd12, 16'd13, 50, 25, 100, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        a = longint'($urandom_range(0, 20)) - 10;
      end else begin
        a = longint'($urandom_range(1, 32'h7fffffff));
      end
      e0 = longint'($urandom_range(0, 1000)) * a / 900 - a / 20;
      e1 = longint'($urandom_range(0, 1000)) * a / 900 - a / 20;
      if (e0 > 64'h7fffffff) e0 = 64'h7fffffff;
      if (e1 > 64'h7fffffff) e1 = 64'h7fffffff;
      run_px(P'($urandom), P'($urandom), e0, e1, a,
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gfx_interp.md
# gfx_interp

Barycentric interpolation stage directly downstream of the triangle rasterizer. Per pixel write it takes the pixel coordinate, the two edge function values and the doubled triangle area, and computes normalized fixed-point weights `factor0 = edge0/area` and `factor1 = edge1/area` with two serial restoring dividers. It then forwards the pixel with its factors to the fragment/texture stage and acknowledges the rasterizer. It exists so that texturing and colour/depth interpolation downstream receive pre-normalized weights.

## Interface
- `point_width`, 16, integer pixel coordinate width; edge and area inputs are `2*point_width` bits.
- `fract_width`, 16, fractional bits of each factor; factors are `fract_width+1` bits (1.F unsigned).
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `write_i`  in  1  pixel valid from rasterizer; sampled only in IDLE.
- `ack_o`  out  1  one-cycle pulse: pixel consumed downstream; rasterizer may advance.
- `x_i`, `y_i`  in  `point_width`  pixel coordinate.
- `edge0_i`, `edge1_i`  in  `2*point_width`  signed edge function values.
- `area_i`  in  `2*point_width`  signed doubled triangle area.
- `write_o`  out  1  pixel + factors valid for downstream; held until `ack_i`.
- `ack_i`  in  1  downstream accepted the pixel.
- `x_o`, `y_o`  out  `point_width`  registered copy of `x_i`/`y_i`.
- `factor0_o`, `factor1_o`, `factor2_o`  out  `fract_width+1`  barycentric weights, 1.0 = `1<<fract_width`.

## Operation
- States: IDLE, DIV, OUT.
- IDLE: on `write_i`, latch x, y, edge0, edge1 and area; load the step counter with `fract_width`; go to DIV. `write_i` outside IDLE is ignored, because the upstream stage holds until `ack_o`.
- Per-divider latch-time classification:
  - area <= 0, or edge < 0: result forced to 0.
  - edge >= area: result forced to `1<<fract_width` (saturate).
  - Otherwise: remainder = edge, quotient = 0; restoring division produces one fractional bit per cycle: rem <<= 1; if rem >= area { rem -= area; bit = 1 }.
- Forced cases still spend `fract_width` cycles in DIV, so latency is constant.
- Remainder width is `2*point_width+1` bits unsigned, so the shift never overflows.
- DIV: decrement the counter each cycle. When the counter reaches 1 (last step), go to OUT and register `write_o`=1 with the final factors and x/y.
- OUT: hold all outputs stable while `ack_i`=0. On `ack_i`: `write_o`<=0, `ack_o`<=1 for exactly one cycle, go to IDLE.
- `ack_o` is 0 in every other cycle.

## Timing
- Reset values: `write_o`=0, `ack_o`=0, `x_o`=`y_o`=0, all factors 0, state IDLE, counter 0.
- Reset asserted mid-DIV or mid-OUT: immediate return to reset values, no `ack_o` emitted.
- `write_i` sampled in cycle 0; DIV occupies cycles 1..`fract_width`; `write_o` is high from cycle `fract_width`+1.
- With `ack_i` high in the first OUT cycle, `ack_o` pulses in cycle `fract_width`+2. Next `write_i` is accepted no earlier than the following cycle.
- Throughput: one pixel per `fract_width`+2 cycles minimum.

## Configuration
- `GFX_INTERP_FACTOR2_EN` defined: `factor2_o` = `(1<<fract_width) - factor0 - factor1`, computed in the OUT-entry cycle, saturated at 0 if negative.
- Not defined: `factor2_o` is tied to 0 and its subtractor is absent. Timing is identical in both builds.

## Structure
- Package `gfx_interp_pkg`: state encoding (IDLE/DIV/OUT), default widths, and the `ONE` constant `1<<fract_width`.
- Sub-module `gfx_interp_divider`: one serial restoring divider with load/step inputs and forced-result handling, instantiated twice (edge0, edge1). The top level holds the FSM, step counter, coordinate registers, handshake and the factor2 logic.

## Test plan
- area=100, edge0=50, edge1=25, F=16 -> `factor0`=0x08000, `factor1`=0x04000, `factor2`=0x04000 (macro on); `write_o` rises exactly 17 cycles after `write_i`.
- edge0=100, area=100 and edge0=150, area=100 -> `factor0`=0x10000 in both cases; edge1=0 -> `factor1`=0.
- area=0 (and separately area=-5) -> all factors 0, same 17-cycle latency, normal `ack_i`/`ack_o` handshake.
- `ack_i` held low 5 cycles in OUT, with `write_i` pulsed during DIV -> outputs stable, pulse ignored; single `ack_o` pulse the cycle after `ack_i`.
- `rst_ni` low at DIV cycle 8 -> all outputs 0 next cycle, no `ack_o`; a fresh `write_i` after release completes normally.
- Macro off, edge0=50, edge1=25, area=100 -> `factor2_o`=0. Macro on, edge0=60, edge1=60, area=100 (sum > 1.0) -> `factor2_o`=0 (saturated).
